// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the async FIFO read-side stream adapter.
package fifo_pgk;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUF_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fifo_rd_state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream, bundled for the read-side adapter.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = fifo_pgk::DEF_DATA_WIDTH
);
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_pop, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_pop, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer absorbing FIFO words that land after the stream stalls.
module fifo_rd_skid_buf #(
  parameter int  DATA_WIDTH = 8,
  parameter int  BUF_DEPTH  = 4,
  localparam int PTR_W      = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [PTR_W:0]        occ
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        occ_q, occ_d;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: storage is not reset; the head is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head_data = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops words and presents them as a
// valid/ready stream, with graceful flush on enable drop and a handshake counter.
module fifo_rd_stream
  import fifo_pgk::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 enable,
  input  logic                 clear_cnt,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt,
  fifo_rd_stream_if.master     bus
);

  localparam int              PTR_W   = $clog2(BUF_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(BUF_DEPTH);

  fifo_rd_state_t       state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W:0]       occ;
  logic [PTR_W+1:0]     pending;
  logic                 pop;
  logic                 hs;

  // Reserve a slot for the word in flight so a capture can never hit a full buffer.
  assign pending = {1'b0, occ} + {{(PTR_W+1){1'b0}}, inflight_q};
  assign pop     = (state_q == RUN) && !bus.fifo_empty && (pending < DEPTH_L);
  assign hs      = bus.m_valid && bus.m_ready;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .wr_en     (inflight_q),
    .wr_data   (bus.fifo_data),
    .rd_en     (hs),
    .head_data (bus.m_data),
    .occ       (occ)
  );

  always_comb begin
    state_d    = state_q;
    inflight_d = pop;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = FLUSH;
      // Flush always completes before honouring a re-asserted enable.
      FLUSH:   if (!inflight_q && occ == '0) state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_cnt)                cnt_d = '0;
    else if (hs && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.m_valid  = (occ != '0);
  assign busy         = (state_q != IDLE);
  assign word_cnt     = cnt_q;

endmodule
